// File: rtl/lr_pkg.sv
// lr_pkg -- shared constants and bus types for the window / inner-product datapath.
// Revision 1.0
`default_nettype none

package lr_pkg;

  localparam int PIX_W     = 7;
  localparam int WIN       = 9;
  localparam int WIN_ELEMS = WIN * WIN;

  typedef logic [PIX_W-1:0]           pixel_t;
  // Element i = r*WIN + c sits at bits [i*PIX_W +: PIX_W]; r=0 is the oldest row.
  typedef logic [WIN_ELEMS*PIX_W-1:0] window_t;

endpackage

`default_nettype wire

// File: rtl/linebuffer_column_store.sv
// linebuffer_column_store -- ROWS x IMG_W pixel memory with column read and shift-up write.
// Revision 1.0
`default_nettype none

module linebuffer_column_store #(
  parameter int IMG_W  = 28,
  parameter int ROWS   = 8,
  parameter int PIX_W  = 7,
  parameter int ADDR_W = $clog2(IMG_W)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [PIX_W-1:0]      wr_pixel,
  output logic [ROWS*PIX_W-1:0] rd_column
);

  // Row 0 holds the oldest line; contents are never reset.
  logic [PIX_W-1:0] mem [ROWS][IMG_W];

  generate
    for (genvar k = 0; k < ROWS; k++) begin : g_rd
      assign rd_column[k*PIX_W +: PIX_W] = mem[k][addr];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < ROWS - 1; k++) begin
        mem[k][addr] <= mem[k+1][addr];
      end
      mem[ROWS-1][addr] <= wr_pixel;
    end
  end

endmodule

`default_nettype wire

// File: rtl/linebuffer_window9.sv
// linebuffer_window9 -- raster pixel stream to 9x9 sliding window, one window per accepted pixel.
// Revision 1.0
`default_nettype none

module linebuffer_window9 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PIX_W = lr_pkg::PIX_W,
  parameter int WIN   = lr_pkg::WIN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PIX_W-1:0]         in_pixel,
  input  logic                     in_sof,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIN*WIN*PIX_W-1:0] out_window,
  output logic [4:0]               out_x,
  output logic [4:0]               out_y,
  output logic                     out_last
);

  localparam int ROWS  = WIN - 1;
  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_MIN  = COL_W'(WIN - 1);
  localparam logic [ROW_W-1:0] ROW_MIN  = ROW_W'(WIN - 1);

  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic [COL_W-1:0]         pos_col;
  logic [ROW_W-1:0]         pos_row;
  logic                     accept;
  logic                     consume;
  logic                     win_ok;
  logic [ROWS*PIX_W-1:0]    lb_column;
  logic [WIN*WIN*PIX_W-1:0] win_next;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid && out_ready;

  // A start-of-frame pixel is (0,0) no matter where the counters were.
  assign pos_col = in_sof ? '0 : col;
  assign pos_row = in_sof ? '0 : row;
  assign win_ok  = (pos_row >= ROW_MIN) && (pos_col >= COL_MIN);

  linebuffer_column_store #(
    .IMG_W  (IMG_W),
    .ROWS   (ROWS),
    .PIX_W  (PIX_W),
    .ADDR_W (COL_W)
  ) u_store (
    .clk       (clk),
    .wr_en     (accept),
    .addr      (pos_col),
    .wr_pixel  (in_pixel),
    .rd_column (lb_column)
  );

  // Shift every window row left; the fresh column enters at the right edge.
  generate
    for (genvar r = 0; r < WIN; r++) begin : g_row
      for (genvar c = 0; c < WIN - 1; c++) begin : g_shift
        assign win_next[(r*WIN+c)*PIX_W +: PIX_W] = out_window[(r*WIN+c+1)*PIX_W +: PIX_W];
      end
      if (r < ROWS) begin : g_from_lb
        assign win_next[(r*WIN+WIN-1)*PIX_W +: PIX_W] = lb_column[r*PIX_W +: PIX_W];
      end else begin : g_from_in
        assign win_next[(r*WIN+WIN-1)*PIX_W +: PIX_W] = in_pixel;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (pos_col == COL_LAST) begin
        col <= '0;
        row <= (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
      end else begin
        col <= pos_col + 1'b1;
        row <= pos_row;
      end
    end
  end

  // The window register doubles as the output bus; it only moves on accept,
  // so it is frozen whenever a window is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_x      <= '0;
      out_y      <= '0;
      out_window <= '0;
    end else if (accept) begin
      out_window <= win_next;
      out_valid  <= win_ok;
      if (win_ok) begin
        out_x    <= 5'(pos_col - COL_MIN);
        out_y    <= 5'(pos_row - ROW_MIN);
        out_last <= (pos_row == ROW_LAST) && (pos_col == COL_LAST);
      end
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_linebuffer_window9.sv
// tb_linebuffer_window9 -- randomized self-checking bench against a frame-array window model.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_linebuffer_window9;
  import lr_pkg::*;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int NPIX  = IMG_W * IMG_H;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  pixel_t     in_pixel;
  logic       in_sof;
  logic       out_valid;
  logic       out_ready;
  window_t    out_window;
  logic [4:0] out_x;
  logic [4:0] out_y;
  logic       out_last;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  linebuffer_window9 #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pixel   (in_pixel),
    .in_sof     (in_sof),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window),
    .out_x      (out_x),
    .out_y      (out_y),
    .out_last   (out_last)
  );

  typedef struct {
    int      x;
    int      y;
    bit      last;
    window_t w;
  } win_rec_t;

  // Reference model: the whole frame as a 2-D array, windows cut straight out of it.
  pixel_t     img [IMG_H][IMG_W];
  int         m_r, m_c;
  win_rec_t   exp_q[$];
  win_rec_t   seen_q[$];
  win_rec_t   ref_q[$];
  logic [7:0] stim_q[$];
  int         mism;
  int         timeouts;
  string      first_bad;

  function automatic pixel_t pattern(input int r, input int c);
    return pixel_t'((r * 28 + c) % 128);
  endfunction

  task automatic model_reset();
    m_r = 0;
    m_c = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input bit sof, input pixel_t p);
    win_rec_t e;
    if (sof) begin
      m_r = 0;
      m_c = 0;
    end
    img[m_r][m_c] = p;
    if (m_r >= 8 && m_c >= 8) begin
      e.x    = m_c - 8;
      e.y    = m_r - 8;
      e.last = (m_r == IMG_H - 1) && (m_c == IMG_W - 1);
      for (int i = 0; i < 81; i++) e.w[i*7 +: 7] = img[m_r - 8 + i / 9][m_c - 8 + i % 9];
      exp_q.push_back(e);
    end
    m_c++;
    if (m_c == IMG_W) begin
      m_c = 0;
      m_r++;
      if (m_r == IMG_H) m_r = 0;
    end
  endtask

  task automatic push_pixels(input int from, input int to, input bit rnd);
    pixel_t p;
    for (int k = from; k <= to; k++) begin
      p = rnd ? pixel_t'($urandom) : pattern(k / IMG_W, k % IMG_W);
      stim_q.push_back({(k == 0), p});
    end
  endtask

  // Streams stim_q into the DUT; every consumed window is logged and checked
  // against the model queue (mismatches tallied into mism for the caller).
  task automatic run_stream(input int valid_pct, input int ready_pct, input bit drain);
    win_rec_t s;
    win_rec_t e;
    int budget;
    budget    = 40000;
    mism      = 0;
    timeouts  = 0;
    first_bad = "none";
    while ((stim_q.size() > 0 || (drain && exp_q.size() > 0)) && budget > 0) begin
      @(negedge clk);
      budget--;
      in_valid = (stim_q.size() > 0) && ($urandom_range(99) < valid_pct);
      {in_sof, in_pixel} = in_valid ? stim_q[0] : 8'h00;
      out_ready = ($urandom_range(99) < ready_pct) || (stim_q.size() == 0);
      #1;
      if (out_valid && out_ready) begin
        s.x = int'(out_x); s.y = int'(out_y); s.last = out_last; s.w = out_window;
        seen_q.push_back(s);
        if (exp_q.size() == 0) begin
          if (mism == 0) first_bad = $sformatf("unexpected window x=%0d y=%0d", s.x, s.y);
          mism++;
        end else begin
          e = exp_q.pop_front();
          if (e.x != s.x || e.y != s.y || e.last != s.last || e.w !== s.w) begin
            if (mism == 0)
              first_bad = $sformatf("got x=%0d y=%0d last=%0b, want x=%0d y=%0d last=%0b data_eq=%0b",
                                    s.x, s.y, s.last, e.x, e.y, e.last, (e.w === s.w));
            mism++;
          end
        end
      end
      if (in_valid && in_ready) begin
        model_accept(in_sof, in_pixel);
        void'(stim_q.pop_front());
      end
    end
    if (budget == 0) timeouts++;
    @(negedge clk);
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    checks++; if (out_x !== 5'd0 || out_y !== 5'd0) begin failures++; $display("FAIL reset_xy got=%0d,%0d want=0,0", out_x, out_y); end
    checks++; if (out_window !== '0) begin failures++; $display("FAIL reset_window got nonzero want=0"); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_first_window();
    int early;
    window_t w;
    early = 0;
    for (int k = 0; k <= 8 * IMG_W + 8; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sof = (k == 0); in_pixel = pattern(k / IMG_W, k % IMG_W); out_ready = 1'b1;
      #1;
      if (out_valid !== 1'b0) early++;
      if (in_ready) model_accept(in_sof, in_pixel);
    end
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
    #1;
    w = out_window;
    checks++; if (early !== 0) begin failures++; $display("FAIL first_early_valid got=%0d cycles want=0", early); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL first_valid got=%b want=1", out_valid); end
    checks++; if (out_x !== 5'd0 || out_y !== 5'd0 || out_last !== 1'b0) begin failures++; $display("FAIL first_pos got x=%0d y=%0d last=%b want 0,0,0", out_x, out_y, out_last); end
    checks++; if (w[0 +: 7] !== 7'd0) begin failures++; $display("FAIL first_elem0 got=%0d want=0", w[0 +: 7]); end
    checks++; if (w[8*7 +: 7] !== 7'd8) begin failures++; $display("FAIL first_elem8 got=%0d want=8", w[8*7 +: 7]); end
    checks++; if (w[72*7 +: 7] !== 7'd96) begin failures++; $display("FAIL first_elem72 got=%0d want=96", w[72*7 +: 7]); end
    checks++; if (w[80*7 +: 7] !== 7'd104) begin failures++; $display("FAIL first_elem80 got=%0d want=104", w[80*7 +: 7]); end
  endtask

  // Continues the frame left open by test_first_window.
  task automatic test_backpressure();
    window_t saved;
    saved = out_window;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sof = 1'b0; in_pixel = pattern(8, 9); out_ready = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall_in_ready cycle=%0d got=%b want=0", i, in_ready); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_out_valid cycle=%0d got=%b want=1", i, out_valid); end
      checks++; if (out_window !== saved) begin failures++; $display("FAIL stall_window_stable cycle=%0d changed while stalled", i); end
    end
    seen_q.delete();
    push_pixels(8 * IMG_W + 9, NPIX - 1, 1'b0);
    run_stream(100, 60, 1'b1);
    checks++; if (mism !== 0) begin failures++; $display("FAIL bp_windows mismatches=%0d want=0 first: %s", mism, first_bad); end
    checks++; if (timeouts !== 0) begin failures++; $display("FAIL bp_timeout got=%0d want=0", timeouts); end
    checks++; if (seen_q.size() !== 400) begin failures++; $display("FAIL bp_count got=%0d want=400", seen_q.size()); end
  endtask

  task automatic test_window_count();
    int lasts, bad_pos;
    seen_q.delete();
    push_pixels(0, NPIX - 1, 1'b0);
    run_stream(100, 100, 1'b1);
    ref_q = seen_q;
    lasts = 0; bad_pos = 0;
    foreach (seen_q[i]) begin
      if (seen_q[i].last) lasts++;
      if (seen_q[i].x > 19 || seen_q[i].y > 19) bad_pos++;
    end
    checks++; if (mism !== 0) begin failures++; $display("FAIL count_windows mismatches=%0d want=0 first: %s", mism, first_bad); end
    checks++; if (seen_q.size() !== 400) begin failures++; $display("FAIL count_total got=%0d want=400", seen_q.size()); end
    checks++; if (lasts !== 1 || bad_pos !== 0) begin failures++; $display("FAIL count_flags lasts=%0d outside=%0d want 1,0", lasts, bad_pos); end
    if (seen_q.size() > 0) begin
      checks++;
      if (seen_q[$].x !== 19 || seen_q[$].y !== 19 || seen_q[$].last !== 1'b1) begin
        failures++;
        $display("FAIL count_last got x=%0d y=%0d last=%0b want 19,19,1", seen_q[$].x, seen_q[$].y, seen_q[$].last);
      end
    end
  endtask

  task automatic test_bubbles();
    int diffs;
    seen_q.delete();
    push_pixels(0, NPIX - 1, 1'b0);
    run_stream(50, 100, 1'b1);
    diffs = 0;
    if (seen_q.size() == ref_q.size()) begin
      foreach (seen_q[i])
        if (seen_q[i].x != ref_q[i].x || seen_q[i].y != ref_q[i].y || seen_q[i].w !== ref_q[i].w) diffs++;
    end
    checks++; if (mism !== 0) begin failures++; $display("FAIL bubble_windows mismatches=%0d want=0 first: %s", mism, first_bad); end
    checks++; if (seen_q.size() !== ref_q.size()) begin failures++; $display("FAIL bubble_count got=%0d want=%0d", seen_q.size(), ref_q.size()); end
    checks++; if (diffs !== 0) begin failures++; $display("FAIL bubble_vs_fullrate differing=%0d want=0", diffs); end
  endtask

  task automatic test_sof_mid_frame();
    seen_q.delete();
    push_pixels(0, 12 * IMG_W + 2, 1'b0);
    push_pixels(0, NPIX - 1, 1'b1);
    run_stream(80, 80, 1'b1);
    checks++; if (mism !== 0) begin failures++; $display("FAIL sof_windows mismatches=%0d want=0 first: %s", mism, first_bad); end
    checks++; if (seen_q.size() !== 480) begin failures++; $display("FAIL sof_count got=%0d want=480", seen_q.size()); end
    if (seen_q.size() > 80) begin
      checks++;
      if (seen_q[79].x !== 19 || seen_q[79].y !== 3 || seen_q[80].x !== 0 || seen_q[80].y !== 0) begin
        failures++;
        $display("FAIL sof_boundary got (%0d,%0d)->(%0d,%0d) want (19,3)->(0,0)",
                 seen_q[79].x, seen_q[79].y, seen_q[80].x, seen_q[80].y);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    push_pixels(0, 9 * IMG_W + 10, 1'b0);
    run_stream(100, 100, 1'b0);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_pending_valid got=%b want=1", out_valid); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_in_ready got=%b want=1", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    seen_q.delete();
    push_pixels(0, NPIX - 1, 1'b1);
    run_stream(90, 80, 1'b1);
    checks++; if (mism !== 0) begin failures++; $display("FAIL rst_frame_windows mismatches=%0d want=0 first: %s", mism, first_bad); end
    checks++; if (seen_q.size() !== 400) begin failures++; $display("FAIL rst_frame_count got=%0d want=400", seen_q.size()); end
  endtask

  initial begin
    test_reset();
    test_first_window();
    test_backpressure();
    test_window_count();
    test_bubbles();
    test_sof_mid_frame();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
